// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario collision-probe scheduler.
package mario_pkg;

  localparam logic [2:0] TILE_AIR    = 3'b000;
  localparam logic [2:0] TILE_OFFMAP = 3'b111;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_COMMIT} poll_state_t;

  // Probe order within one sweep: UP -> DOWN -> LEFT -> RIGHT.
  function automatic dir_t next_dir(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_LEFT;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/mario_probe_addr.sv
// Maps a position snapshot plus probe direction to a tile-map address and an off-map flag.
module mario_probe_addr
  import mario_pkg::*;
#(
  parameter int TILE_SHIFT  = 4,
  parameter int MAP_COLS_LG = 6,
  parameter int MAP_ROWS    = 30,
  parameter int ADDR_W      = 11,
  parameter int HALF_X      = 20,
  parameter int HALF_Y      = 20
) (
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic [10:0]       scroll_i,
  input  dir_t              dir_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              off_map_o
);

  // 13 bits signed covers X + Scroll_X + HALF_X without wrapping.
  localparam int CW = 13;

  logic signed [CW-1:0] wx, wy, px, py;
  logic        [CW-1:0] col, row;

  // Probe point selection, tile coordinates and range check.
  always_comb begin
    wx = $signed({3'b000, x_i}) + $signed({2'b00, scroll_i});
    wy = $signed({3'b000, y_i});
    px = wx;
    py = wy;
    case (dir_i)
      DIR_UP:   py = wy - CW'(HALF_Y + 1);
      DIR_DOWN: py = wy + CW'(HALF_Y);
      DIR_LEFT: px = wx - CW'(HALF_X + 1);
      default:  px = wx + CW'(HALF_X);
    endcase
    col       = px >>> TILE_SHIFT;
    row       = py >>> TILE_SHIFT;
    off_map_o = px[CW-1] | py[CW-1] | (row >= CW'(MAP_ROWS)) | (col >= CW'(2 ** MAP_COLS_LG));
    addr_o    = off_map_o ? '0 : ADDR_W'((row << MAP_COLS_LG) + col);
  end

endmodule

// File: rtl/mario_poll_scheduler.sv
// Once-per-frame sweep of the four collision probes through the shared tile-map read port.
module mario_poll_scheduler
  import mario_pkg::*;
#(
  parameter int TILE_SHIFT  = 4,
  parameter int MAP_COLS_LG = 6,
  parameter int MAP_ROWS    = 30,
  parameter int ADDR_W      = 11,
  parameter int HALF_X      = 20,
  parameter int HALF_Y      = 20,
  parameter int STARVE_MAX  = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        Mario_X_Pos,
  input  logic [9:0]        Mario_Y_Pos,
  input  logic [10:0]       Scroll_X,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_grant,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [2:0]        ram_data,
  output logic [2:0]        mario_poll_up,
  output logic [2:0]        mario_poll_down,
  output logic [2:0]        mario_poll_left,
  output logic [2:0]        mario_poll_right,
  output logic              poll_valid,
  output logic              poll_busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  poll_state_t       state_q, state_d;
  dir_t              dir_q, dir_d;
  logic              frame_meta_q, frame_sync_q, frame_prev_q, frame_edge;
  logic              pending_q, pending_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [9:0]        x_q, y_q;
  logic [10:0]       scroll_q;
  logic [3:0][2:0]   shadow_q, shadow_d, polls_q;
  logic              snap_en, commit, force_poll;
  logic [ADDR_W-1:0] probe_addr;
  logic              probe_off;

  assign frame_edge = frame_sync_q & ~frame_prev_q;

  mario_probe_addr #(
    .TILE_SHIFT (TILE_SHIFT),
    .MAP_COLS_LG(MAP_COLS_LG),
    .MAP_ROWS   (MAP_ROWS),
    .ADDR_W     (ADDR_W),
    .HALF_X     (HALF_X),
    .HALF_Y     (HALF_Y)
  ) u_probe (
    .x_i      (x_q),
    .y_i      (y_q),
    .scroll_i (scroll_q),
    .dir_i    (dir_q),
    .addr_o   (probe_addr),
    .off_map_o(probe_off)
  );

  // State, synchroniser, snapshot, starve counter, shadow and committed outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      dir_q        <= DIR_UP;
      frame_meta_q <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_prev_q <= 1'b0;
      pending_q    <= 1'b0;
      starve_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      scroll_q     <= '0;
      shadow_q     <= '0;
      polls_q      <= {4{TILE_AIR}};
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      frame_meta_q <= frame_clk;
      frame_sync_q <= frame_meta_q;
      frame_prev_q <= frame_sync_q;
      pending_q    <= pending_d;
      starve_q     <= starve_d;
      shadow_q     <= shadow_d;
      if (snap_en) begin
        x_q      <= Mario_X_Pos;
        y_q      <= Mario_Y_Pos;
        scroll_q <= Scroll_X;
      end
      if (commit) polls_q <= shadow_d;
    end
  end

  // Sweep sequencing and RAM port arbitration.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pending_d    = pending_q | frame_edge;
    starve_d     = starve_q;
    shadow_d     = shadow_q;
    snap_en      = 1'b0;
    commit       = 1'b0;
    force_poll   = 1'b0;
    render_grant = render_req;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          pending_d = frame_edge;
          snap_en   = 1'b1;
          dir_d     = DIR_UP;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (probe_off) begin
          shadow_d[dir_q] = TILE_OFFMAP;
          state_d         = S_CAPTURE;
        end else begin
          force_poll   = (starve_q == SW'(STARVE_MAX));
          render_grant = render_req & ~force_poll;
          if (render_grant) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = '0;
            state_d  = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        // Off-map slots already hold TILE_OFFMAP from the ISSUE cycle.
        if (!probe_off) shadow_d[dir_q] = ram_data;
        if (dir_q == DIR_RIGHT) begin
          commit  = 1'b1;
          state_d = S_COMMIT;
        end else begin
          dir_d   = next_dir(dir_q);
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ram_addr = render_grant ? render_addr : ((state_q == S_IDLE) ? '0 : probe_addr);
  end

  assign poll_valid       = (state_q == S_COMMIT);
  assign poll_busy        = (state_q == S_ISSUE) || (state_q == S_CAPTURE);
  assign mario_poll_up    = polls_q[DIR_UP];
  assign mario_poll_down  = polls_q[DIR_DOWN];
  assign mario_poll_left  = polls_q[DIR_LEFT];
  assign mario_poll_right = polls_q[DIR_RIGHT];

endmodule

// File: tb/tb_mario_poll_scheduler.sv
// Scoreboard bench for mario_poll_scheduler: a tile-map RAM model feeds the DUT, expected
// sweeps are queued at each frame tick and compared when poll_valid pulses.
module tb_mario_poll_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [9:0]  Mario_X_Pos, Mario_Y_Pos;
  logic [10:0] Scroll_X;
  logic        render_req;
  logic [10:0] render_addr;
  logic        render_grant;
  logic [10:0] ram_addr;
  logic [2:0]  ram_data = 3'b000;
  logic [2:0]  mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right;
  logic        poll_valid, poll_busy;

  typedef struct {
    logic [2:0] up, down, left, right;
    int         t0;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] tmap [2048];
  bit         seen [2048];
  int         cyc = 0;
  int         checks = 0, errors = 0;
  int         rd_cycles = 0, forced = 0, valid_cnt = 0;

  mario_poll_scheduler dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .frame_clk       (frame_clk),
    .Mario_X_Pos     (Mario_X_Pos),
    .Mario_Y_Pos     (Mario_Y_Pos),
    .Scroll_X        (Scroll_X),
    .render_req      (render_req),
    .render_addr     (render_addr),
    .render_grant    (render_grant),
    .ram_addr        (ram_addr),
    .ram_data        (ram_data),
    .mario_poll_up   (mario_poll_up),
    .mario_poll_down (mario_poll_down),
    .mario_poll_left (mario_poll_left),
    .mario_poll_right(mario_poll_right),
    .poll_valid      (poll_valid),
    .poll_busy       (poll_busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous-read tile-map RAM.
  always @(posedge Clk) ram_data <= tmap[ram_addr];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference tile lookup using plain integer division.
  function automatic logic [2:0] tile_at(input int x, input int y);
    int col, row;
    if (x < 0 || y < 0) return 3'b111;
    col = x / 16;
    row = y / 16;
    if (row >= 30 || col >= 64) return 3'b111;
    return tmap[row * 64 + col];
  endfunction

  task automatic push_expect(input int x, input int y, input int s, input int lat);
    exp_t e;
    int   wx;
    wx      = x + s;
    e.up    = tile_at(wx, y - 21);
    e.down  = tile_at(wx, y + 20);
    e.left  = tile_at(wx - 21, y);
    e.right = tile_at(wx + 20, y);
    e.t0    = cyc;
    e.lat   = lat;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse(input int hi);
    frame_clk = 1'b1;
    repeat (hi) step();
    frame_clk = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y, input int s);
    Mario_X_Pos = 10'(x);
    Mario_Y_Pos = 10'(y);
    Scroll_X    = 11'(s);
  endtask

  task automatic clear_monitor();
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
    rd_cycles = 0;
    forced    = 0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) step();
    check_eq("scoreboard_drained", sb_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare on poll_valid, RAM port observation.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (poll_busy && !render_grant && ram_addr != 11'd0) begin
        rd_cycles++;
        seen[ram_addr] = 1'b1;
      end
      if (render_req && !render_grant) forced++;
      if (render_grant) check_eq("grant_addr", ram_addr, render_addr);
      if (poll_valid) begin
        valid_cnt++;
        check_eq("busy_at_commit", poll_busy, 0);
        if (sb_q.size() == 0) begin
          check_eq("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("poll_up", mario_poll_up, e.up);
          check_eq("poll_down", mario_poll_down, e.down);
          check_eq("poll_left", mario_poll_left, e.left);
          check_eq("poll_right", mario_poll_right, e.right);
          if (e.lat >= 0) check_eq("latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [2:0] held;
    for (int i = 0; i < 2048; i++) tmap[i] = 3'($urandom_range(0, 7));
    tmap[26 * 64 + 8] = 3'b010;
    Reset_n     = 1'b0;
    frame_clk   = 1'b0;
    render_req  = 1'b0;
    render_addr = '0;
    set_pos(0, 0, 0);
    repeat (3) step();

    // Reset state
    check_eq("rst_up", mario_poll_up, 0);
    check_eq("rst_right", mario_poll_right, 0);
    check_eq("rst_valid", poll_valid, 0);
    check_eq("rst_busy", poll_busy, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    Reset_n = 1'b1;
    repeat (2) step();

    // Uncontended sweep: 2 sync + 1 pending + 9 from frame_clk assertion
    clear_monitor();
    set_pos(140, 400, 0);
    push_expect(140, 400, 0, 12);
    frame_pulse(3);
    drain(40);
    check_eq("down_tile_r26c8", mario_poll_down, 3'b010);
    check_eq("uncontended_reads", rd_cycles, 8);
    held = mario_poll_left;
    repeat (10) step();
    check_eq("outputs_hold", mario_poll_left, held);

    // UP probe above the map: off-map code, no RAM access for it
    clear_monitor();
    set_pos(140, 10, 0);
    push_expect(140, 10, 0, 12);
    frame_pulse(3);
    drain(40);
    check_eq("offmap_up", mario_poll_up, 3'b111);
    check_eq("offmap_reads", rd_cycles, 6);

    // Scroll: RIGHT probe lands in column (160+64)>>4 = 14, row 25
    clear_monitor();
    set_pos(140, 400, 64);
    push_expect(140, 400, 64, 12);
    frame_pulse(3);
    drain(40);
    check_eq("scroll_right_addr", seen[25 * 64 + 14], 1);

    // Contention: renderer holds the port; one forced slot per direction
    clear_monitor();
    render_req  = 1'b1;
    render_addr = 11'h155;
    set_pos(300, 200, 100);
    push_expect(300, 200, 100, 44);
    frame_pulse(3);
    drain(80);
    check_eq("forced_slots", forced, 4);
    render_req = 1'b0;
    repeat (3) step();

    // Two extra edges during one sweep: exactly one extra sweep
    v0 = valid_cnt;
    set_pos(140, 400, 0);
    push_expect(140, 400, 0, 12);
    push_expect(140, 400, 0, -1);
    frame_pulse(2);
    step();
    frame_pulse(2);
    repeat (2) step();
    frame_pulse(2);
    drain(60);
    repeat (20) step();
    check_eq("double_edge_valids", valid_cnt - v0, 2);

    // Reset mid-sweep: partial sweep discarded
    v0 = valid_cnt;
    set_pos(500, 300, 0);
    frame_pulse(3);
    repeat (3) step();
    check_eq("busy_mid_sweep", poll_busy, 1);
    Reset_n = 1'b0;
    #1;
    check_eq("midrst_up", mario_poll_up, 0);
    check_eq("midrst_down", mario_poll_down, 0);
    check_eq("midrst_busy", poll_busy, 0);
    check_eq("midrst_valid", poll_valid, 0);
    step();
    check_eq("midrst_ram_addr", ram_addr, 0);
    Reset_n = 1'b1;
    repeat (30) step();
    check_eq("no_valid_after_reset", valid_cnt - v0, 0);
    check_eq("post_rst_left", mario_poll_left, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
